// File: rtl/conv_layer_stream.sv
// Streaming 2-D convolution: raster-order pixels in, one multi-channel result per
// qualifying window out, through a 3-stage capture / MAC / shift-ReLU-saturate pipeline.
module conv_layer_stream #(
  parameter int D_WIDTH     = 8,
  parameter int Q_WIDTH     = 8,
  parameter int D_CHANNELS  = 1,
  parameter int Q_CHANNELS  = 1,
  parameter int FILTER_SIZE = 3,
  parameter int IMAGE_SIZE  = 8,
  parameter int STRIDE      = 1,
  parameter int SHIFT       = 0,
  parameter int RELU        = 0,
  localparam int NW   = Q_CHANNELS * D_CHANNELS * FILTER_SIZE * FILTER_SIZE,
  localparam int WA_W = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [D_WIDTH*D_CHANNELS-1:0]   in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            w_wr_en,
  input  logic [WA_W-1:0]                 w_wr_addr,
  input  logic [D_WIDTH-1:0]              w_wr_data,
  output logic [Q_WIDTH*Q_CHANNELS-1:0]   out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last
);

  localparam int F        = FILTER_SIZE;
  localparam int N        = IMAGE_SIZE;
  localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam int PW       = 2 * D_WIDTH;
  localparam int ACC_W    = 2 * D_WIDTH + $clog2(D_CHANNELS * F * F);
  localparam int LAST_POS = (F - 1) + ((N - F) / STRIDE) * STRIDE;

  localparam logic signed [ACC_W-1:0] Q_MAX = {{(ACC_W-Q_WIDTH+1){1'b0}}, {(Q_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Q_MIN = {{(ACC_W-Q_WIDTH+1){1'b1}}, {(Q_WIDTH-1){1'b0}}};

  logic [CNT_W-1:0] row, col;
  logic             stall, accept, win_hit, win_last;
  logic             s1_valid, s1_last, s2_valid, s2_last;

  logic signed [D_WIDTH-1:0] weights [NW];
  logic signed [D_WIDTH-1:0] win     [D_CHANNELS][F][F];
  logic signed [D_WIDTH-1:0] lbuf    [D_CHANNELS][F-1][N];
  logic signed [D_WIDTH-1:0] pix     [D_CHANNELS];
  logic signed [ACC_W-1:0]   sum_c   [Q_CHANNELS];
  logic signed [ACC_W-1:0]   acc     [Q_CHANNELS];
  logic signed [PW-1:0]      prod_c;
  logic signed [ACC_W-1:0]   clamp_c;
  logic [Q_WIDTH*Q_CHANNELS-1:0] result_c;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall && !rst;
  assign accept   = in_valid && in_ready;

  // True when a row/column index lies on the stride grid of window anchors.
  function automatic logic on_grid(input logic [CNT_W-1:0] pos);
    int p;
    p = int'(pos);
    return (p >= F - 1) && (((p - (F - 1)) % STRIDE) == 0);
  endfunction

  assign win_hit  = on_grid(row) && on_grid(col);
  assign win_last = (row == CNT_W'(LAST_POS)) && (col == CNT_W'(LAST_POS));

  always_comb begin
    for (int d = 0; d < D_CHANNELS; d++) pix[d] = in_data[D_WIDTH*d +: D_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      if (accept) begin
        if (col == CNT_W'(N - 1)) begin
          col <= '0;
          row <= (row == CNT_W'(N - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      s1_valid  <= accept && win_hit;
      s1_last   <= accept && win_hit && win_last;
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= result_c;
        out_last <= s2_last;
      end
    end
  end

  // Weight writes are independent of the stream handshake, so they proceed during stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) weights[i] <= '0;
    end else if (w_wr_en && (int'(w_wr_addr) < NW)) begin
      weights[w_wr_addr] <= w_wr_data;
    end
  end

  // S1: window shifts left; new right column is the line-buffer column plus the new pixel.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int d = 0; d < D_CHANNELS; d++) begin
        for (int r = 0; r < F; r++) begin
          for (int c = 0; c < F - 1; c++) win[d][r][c] <= win[d][r][c+1];
        end
        for (int r = 0; r < F - 1; r++) win[d][r][F-1] <= lbuf[d][r][col];
        win[d][F-1][F-1] <= pix[d];
        for (int k = 0; k < F - 2; k++) lbuf[d][k][col] <= lbuf[d][k+1][col];
        lbuf[d][F-2][col] <= pix[d];
      end
    end
  end

  always_comb begin
    prod_c = '0;
    for (int q = 0; q < Q_CHANNELS; q++) begin
      sum_c[q] = '0;
      for (int d = 0; d < D_CHANNELS; d++) begin
        for (int r = 0; r < F; r++) begin
          for (int c = 0; c < F; c++) begin
            prod_c   = PW'(win[d][r][c]) * PW'(weights[(q*D_CHANNELS + d)*F*F + r*F + c]);
            sum_c[q] = sum_c[q] + ACC_W'(prod_c);
          end
        end
      end
    end
  end

  // S2: accumulator register.
  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int q = 0; q < Q_CHANNELS; q++) acc[q] <= sum_c[q];
    end
  end

  // S3 combinational part: shift, optional ReLU, saturate to Q_WIDTH.
  always_comb begin
    result_c = '0;
    clamp_c  = '0;
    for (int q = 0; q < Q_CHANNELS; q++) begin
      clamp_c = acc[q] >>> SHIFT;
      if ((RELU != 0) && (clamp_c < 0)) clamp_c = '0;
      if (clamp_c > Q_MAX) clamp_c = Q_MAX;
      else if (clamp_c < Q_MIN) clamp_c = Q_MIN;
      result_c[Q_WIDTH*q +: Q_WIDTH] = clamp_c[Q_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_conv_layer_stream.sv
// Randomized bench for conv_layer_stream: a frame-level convolution model feeds an
// expected-result queue that a negedge monitor drains against the DUT output stream.
module tb_conv_layer_stream;

  localparam int DW = 8;
  localparam int QW = 8;
  localparam int DC = 2;
  localparam int QC = 2;
  localparam int F  = 3;
  localparam int N  = 7;
  localparam int S  = 2;
  localparam int SH = 1;
  localparam int RL = 0;
  localparam int NW = QC * DC * F * F;
  localparam int AW = $clog2(NW);

  logic              clk = 1'b0;
  logic              rst;
  logic [DW*DC-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic              w_wr_en;
  logic [AW-1:0]     w_wr_addr;
  logic [DW-1:0]     w_wr_data;
  logic [QW*QC-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  always #5 clk = ~clk;

  conv_layer_stream #(
    .D_WIDTH(DW), .Q_WIDTH(QW), .D_CHANNELS(DC), .Q_CHANNELS(QC),
    .FILTER_SIZE(F), .IMAGE_SIZE(N), .STRIDE(S), .SHIFT(SH), .RELU(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  typedef struct {
    logic [QW*QC-1:0] data;
    logic             last;
    int               beat;
  } exp_t;

  exp_t exp_q[$];
  int   frame_pix [N*N][DC];
  int   wt [NW];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   rdy_mode = 0;
  bit   lat_check = 1'b0;
  int   beat_cnt = 0;
  int   acc_cyc [N*N];
  logic [QW*QC-1:0] held_data;
  logic             held_last;
  bit               was_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
  endtask

  // Reference: direct sliding-window correlation over the stored frame.
  task automatic model_frame();
    for (int r = F - 1; r < N; r += S) begin
      for (int c = F - 1; c < N; c += S) begin
        exp_t e;
        e.data = '0;
        e.last = 1'b0;
        e.beat = r * N + c;
        for (int q = 0; q < QC; q++) begin
          longint a;
          logic [63:0] bits;
          a = 0;
          for (int d = 0; d < DC; d++)
            for (int kr = 0; kr < F; kr++)
              for (int kc = 0; kc < F; kc++)
                a += wt[(q*DC + d)*F*F + kr*F + kc] * frame_pix[(r-F+1+kr)*N + (c-F+1+kc)][d];
          a = a >>> SH;
          if (RL != 0 && a < 0) a = 0;
          if (a > (2**(QW-1)) - 1) a = (2**(QW-1)) - 1;
          if (a < -(2**(QW-1))) a = -(2**(QW-1));
          bits = a;
          e.data[QW*q +: QW] = bits[QW-1:0];
        end
        exp_q.push_back(e);
      end
    end
    exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  task automatic fill_pix(input int lo, input int hi);
    for (int b = 0; b < N*N; b++)
      for (int d = 0; d < DC; d++) frame_pix[b][d] = lo + int'($urandom_range(hi - lo));
  endtask

  task automatic fill_wt(input int lo, input int hi);
    for (int i = 0; i < NW; i++) wt[i] = lo + int'($urandom_range(hi - lo));
  endtask

  task automatic write_weights();
    for (int i = 0; i < NW; i++) begin
      w_wr_en   = 1'b1;
      w_wr_addr = AW'(i);
      w_wr_data = DW'(wt[i]);
      @(posedge clk); #1;
    end
    w_wr_en = 1'b0;
  endtask

  task automatic wait_accept();
    int t;
    bit ok;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 500) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input bit gaps);
    for (int b = 0; b < N*N; b++) begin
      if (gaps && $urandom_range(3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      for (int d = 0; d < DC; d++) in_data[DW*d +: DW] = DW'(frame_pix[b][d]);
      wait_accept();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      beat_cnt  = 0;
      was_stall = 1'b0;
    end else begin
      if (was_stall) begin
        check("stall_out_valid", out_valid, 1);
        check("stall_out_data", out_data, held_data);
        check("stall_out_last", out_last, held_last);
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        held_data = out_data;
        held_last = out_last;
        was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
      if (in_valid && in_ready) begin
        acc_cyc[beat_cnt] = cyc;
        beat_cnt = (beat_cnt == N*N - 1) ? 0 : beat_cnt + 1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
          if (lat_check) check("latency", cyc - acc_cyc[e.beat], 3);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 400000", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Weights come out of reset as zero.
    for (int i = 0; i < NW; i++) wt[i] = 0;
    lat_check = 1'b1;
    fill_pix(-128, 127); model_frame(); send_frame(1'b0);
    fill_wt(-4, 3); write_weights();
    fill_pix(-8, 7); model_frame(); send_frame(1'b0);
    drain();
    lat_check = 1'b0;

    // Back-to-back frames under random backpressure and input gaps.
    rdy_mode = 1;
    fill_wt(-4, 3); write_weights();
    fill_pix(-8, 7); model_frame(); send_frame(1'b1);
    fill_pix(-8, 7); model_frame(); send_frame(1'b0);
    drain();

    // Full-range values drive both saturation limits.
    fill_wt(-128, 127); write_weights();
    fill_pix(-128, 127); model_frame(); send_frame(1'b1);
    drain();

    // Explicit multi-cycle hold of out_ready low while a result is pending.
    rdy_mode = 0;
    fill_wt(-4, 3); write_weights();
    fill_pix(-8, 7); model_frame();
    fork
      send_frame(1'b0);
      begin
        int t;
        t = 0;
        while (!out_valid && t < 300) begin @(negedge clk); t++; end
        rdy_mode = 2;
        t = 0;
        while (!(out_valid && !out_ready) && t < 300) begin @(negedge clk); t++; end
        check("hold_stall_seen", out_valid && !out_ready, 1);
        repeat (5) @(negedge clk);
        rdy_mode = 0;
      end
    join
    drain();

    // Partial frame with a stalled result, then reset mid-frame.
    rdy_mode = 2;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = DW*DC'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", in_ready, 0);
    rst = 1'b0;
    rdy_mode = 0;
    @(posedge clk); #1;
    check("midrst_queue_empty", exp_q.size(), 0);

    for (int i = 0; i < NW; i++) wt[i] = 0;
    fill_pix(-8, 7); model_frame(); send_frame(1'b0);
    drain();
    rdy_mode = 1;
    fill_wt(-4, 3); write_weights();
    fill_pix(-8, 7); model_frame(); send_frame(1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
